// File: rtl/cpu_debug_link_pkg.sv
// Shared opcodes, FSM states and reply bytes for the CPU debug link command engine.
package cpu_debug_link_pkg;

    typedef enum logic [7:0] {
        OP_RESET = 8'h01,
        OP_RDPC  = 8'h02,
        OP_RUN   = 8'h03,
        OP_STOP  = 8'h04,
        OP_STEP  = 8'h05,
        OP_WRITE = 8'h06
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ARG  = 3'd1,
        EXEC     = 3'd2,
        RST_HOLD = 3'd3,
        STEP_RUN = 3'd4,
        SEND     = 3'd5
    } state_t;

    localparam logic [7:0] ACK_BYTE = 8'hA5;
    localparam logic [7:0] NAK_BYTE = 8'h5A;

    // Number of WORD_W operands that follow each opcode; unknown opcodes take none.
    function automatic logic [1:0] ops_for_opcode(input logic [7:0] op);
        case (op)
            OP_STEP:  return 2'd1;
            OP_WRITE: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_debug_link_tx_ser.sv
// Reply serializer: loads up to NB+1 bytes and shifts them out LSB first on a valid/ready port.
module cpu_debug_link_tx_ser #(
    parameter int NB    = 4,
    parameter int LEN_W = $clog2(NB + 2)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [(NB+1)*8-1:0] load_data,
    input  logic [LEN_W-1:0]    load_len,
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    output logic                done
);

    logic [(NB+1)*8-1:0] shreg;
    logic [LEN_W-1:0]    remaining;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            remaining <= '0;
            tx_valid  <= 1'b0;
        end else if (load) begin
            shreg     <= load_data;
            remaining <= load_len;
            tx_valid  <= (load_len != '0);
        end else if (tx_valid && tx_ready) begin
            shreg     <= shreg >> 8;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
                tx_valid <= 1'b0;
            end
        end
    end

    assign tx_data = shreg[7:0];
    assign done    = tx_valid && tx_ready && (remaining == LEN_W'(1));

endmodule

// File: rtl/cpu_debug_link_ctrl.sv
// Debug/loader command engine: decodes UART byte frames into CPU reset/run/step, memory writes and PC reads.
// Optional build macro CPU_DEBUG_LINK_CHECKSUM_EN adds an XOR checksum byte to every frame and reply.
module cpu_debug_link_ctrl
    import cpu_debug_link_pkg::*;
#(
    parameter int WORD_W       = 32,
    parameter int RESET_CYCLES = 4,
    parameter int TIMEOUT      = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [WORD_W-1:0] pc,
    output logic              cpu_reset,
    output logic              cpu_run,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              rx_overrun,
    output logic [2:0]        state
);

    localparam int NB = WORD_W / 8;
`ifdef CPU_DEBUG_LINK_CHECKSUM_EN
    localparam int CHK_BYTES = 1;
`else
    localparam int CHK_BYTES = 0;
`endif
    localparam int ARG_BYTES = 2 * NB + CHK_BYTES;
    localparam int ARG_W     = ARG_BYTES * 8;
    localparam int BCW       = $clog2(ARG_BYTES + 1);
    localparam int TW        = $clog2(TIMEOUT + 1);
    localparam int RCW       = $clog2(RESET_CYCLES + 1);
    localparam int PAY_W     = (NB + 1) * 8;
    localparam int LEN_W     = $clog2(NB + 2);

    state_t             cur_state;
    logic [7:0]         opcode;
    logic [ARG_W-1:0]   arg_buf;
    logic [BCW-1:0]     byte_cnt;
    logic [BCW-1:0]     args_needed;
    logic [BCW-1:0]     frame_args;
    logic [TW-1:0]      idle_cnt;
    logic [RCW-1:0]     rst_cnt;
    logic [WORD_W-1:0]  step_cnt;
    logic               tx_load;
    logic [PAY_W-1:0]   tx_payload;
    logic [LEN_W-1:0]   tx_len;
    logic               tx_done;
    logic               frame_ok;
    logic               in_busy;
    logic [WORD_W-1:0]  op_a;
    logic [WORD_W-1:0]  op_b;
    logic [PAY_W-1:0]   ack_payload;
    logic [PAY_W-1:0]   nak_payload;
    logic [PAY_W-1:0]   pc_payload;
    logic [LEN_W-1:0]   reply_len;
    logic [LEN_W-1:0]   pc_len;

    assign op_a       = arg_buf[WORD_W-1:0];
    assign op_b       = arg_buf[2*WORD_W-1 -: WORD_W];
    assign frame_args = BCW'(int'(ops_for_opcode(rx_data)) * NB + CHK_BYTES);
    assign in_busy    = (cur_state == EXEC) || (cur_state == RST_HOLD) ||
                        (cur_state == STEP_RUN) || (cur_state == SEND);
    assign state      = cur_state;

`ifdef CPU_DEBUG_LINK_CHECKSUM_EN
    logic [7:0] chk;
    logic [7:0] pc_xor;

    always_comb begin
        pc_xor = '0;
        for (int i = 0; i < NB; i++) begin
            pc_xor = pc_xor ^ pc[i*8 +: 8];
        end
    end

    // A frame whose bytes, checksum included, XOR to zero is intact.
    assign frame_ok    = (chk == 8'h00);
    assign ack_payload = PAY_W'({ACK_BYTE, ACK_BYTE});
    assign nak_payload = PAY_W'({NAK_BYTE, NAK_BYTE});
    assign pc_payload  = {pc_xor, pc};
    assign reply_len   = LEN_W'(2);
    assign pc_len      = LEN_W'(NB + 1);
`else
    assign frame_ok    = 1'b1;
    assign ack_payload = PAY_W'(ACK_BYTE);
    assign nak_payload = PAY_W'(NAK_BYTE);
    assign pc_payload  = {8'h00, pc};
    assign reply_len   = LEN_W'(1);
    assign pc_len      = LEN_W'(NB);
`endif

    // Frame decode and command sequencing; every reply is handed to the serializer on entry to SEND.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= IDLE;
            opcode      <= '0;
            arg_buf     <= '0;
            byte_cnt    <= '0;
            args_needed <= '0;
            idle_cnt    <= '0;
            rst_cnt     <= '0;
            step_cnt    <= '0;
            tx_load     <= 1'b0;
            tx_payload  <= '0;
            tx_len      <= '0;
            cpu_reset   <= 1'b0;
            cpu_run     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rx_overrun  <= 1'b0;
`ifdef CPU_DEBUG_LINK_CHECKSUM_EN
            chk         <= '0;
`endif
        end else begin
            mem_we  <= 1'b0;
            tx_load <= 1'b0;
            case (cur_state)
                IDLE: begin
                    if (rx_valid) begin
                        opcode      <= rx_data;
                        byte_cnt    <= '0;
                        idle_cnt    <= '0;
                        args_needed <= frame_args;
`ifdef CPU_DEBUG_LINK_CHECKSUM_EN
                        chk         <= rx_data;
`endif
                        cur_state   <= (frame_args == '0) ? EXEC : GET_ARG;
                    end
                end
                GET_ARG: begin
                    if (rx_valid) begin
                        for (int i = 0; i < ARG_BYTES; i++) begin
                            if (byte_cnt == BCW'(i)) begin
                                arg_buf[i*8 +: 8] <= rx_data;
                            end
                        end
`ifdef CPU_DEBUG_LINK_CHECKSUM_EN
                        chk      <= chk ^ rx_data;
`endif
                        byte_cnt <= byte_cnt + BCW'(1);
                        idle_cnt <= '0;
                        if (byte_cnt == args_needed - BCW'(1)) begin
                            cur_state <= EXEC;
                        end
                    end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                        tx_payload <= nak_payload;
                        tx_len     <= reply_len;
                        tx_load    <= 1'b1;
                        cur_state  <= SEND;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                EXEC: begin
                    if (!frame_ok) begin
                        tx_payload <= nak_payload;
                        tx_len     <= reply_len;
                        tx_load    <= 1'b1;
                        cur_state  <= SEND;
                    end else begin
                        case (opcode)
                            OP_RESET: begin
                                cpu_run    <= 1'b0;
                                cpu_reset  <= 1'b1;
                                rst_cnt    <= RCW'(RESET_CYCLES - 1);
                                rx_overrun <= 1'b0;
                                cur_state  <= RST_HOLD;
                            end
                            OP_RDPC: begin
                                tx_payload <= pc_payload;
                                tx_len     <= pc_len;
                                tx_load    <= 1'b1;
                                cur_state  <= SEND;
                            end
                            OP_RUN, OP_STOP: begin
                                cpu_run    <= (opcode == OP_RUN);
                                tx_payload <= ack_payload;
                                tx_len     <= reply_len;
                                tx_load    <= 1'b1;
                                cur_state  <= SEND;
                            end
                            OP_STEP: begin
                                // A step count overrides free-running mode; n=0 just stops and acknowledges.
                                if (op_a == '0) begin
                                    cpu_run    <= 1'b0;
                                    tx_payload <= ack_payload;
                                    tx_len     <= reply_len;
                                    tx_load    <= 1'b1;
                                    cur_state  <= SEND;
                                end else begin
                                    cpu_run   <= 1'b1;
                                    step_cnt  <= op_a - WORD_W'(1);
                                    cur_state <= STEP_RUN;
                                end
                            end
                            OP_WRITE: begin
                                mem_addr   <= op_a;
                                mem_wdata  <= op_b;
                                mem_we     <= 1'b1;
                                tx_payload <= ack_payload;
                                tx_len     <= reply_len;
                                tx_load    <= 1'b1;
                                cur_state  <= SEND;
                            end
                            default: begin
                                tx_payload <= nak_payload;
                                tx_len     <= reply_len;
                                tx_load    <= 1'b1;
                                cur_state  <= SEND;
                            end
                        endcase
                    end
                end
                RST_HOLD: begin
                    if (rst_cnt == '0) begin
                        cpu_reset  <= 1'b0;
                        tx_payload <= ack_payload;
                        tx_len     <= reply_len;
                        tx_load    <= 1'b1;
                        cur_state  <= SEND;
                    end else begin
                        rst_cnt <= rst_cnt - RCW'(1);
                    end
                end
                STEP_RUN: begin
                    if (step_cnt == '0) begin
                        cpu_run    <= 1'b0;
                        tx_payload <= ack_payload;
                        tx_len     <= reply_len;
                        tx_load    <= 1'b1;
                        cur_state  <= SEND;
                    end else begin
                        step_cnt <= step_cnt - WORD_W'(1);
                    end
                end
                SEND: begin
                    if (tx_done) begin
                        cur_state <= IDLE;
                    end
                end
                default: cur_state <= IDLE;
            endcase
            if (rx_valid && in_busy) begin
                rx_overrun <= 1'b1;
            end
        end
    end

    cpu_debug_link_tx_ser #(
        .NB    (NB),
        .LEN_W (LEN_W)
    ) u_tx_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (tx_load),
        .load_data (tx_payload),
        .load_len  (tx_len),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .done      (tx_done)
    );

endmodule
